// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor in the refclk domain: pulses pll_rst, qualifies lock, releases sys_rst.
// Optional lock-loss counter is enabled by defining PLL_RESET_SEQUENCER_LOSS_CNT_EN.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 256,
    parameter int MAX_RETRIES   = 3,
    localparam int MAX_CYC = (RST_CYCLES > LOCK_TIMEOUT)
                           ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                           : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES),
    localparam int CW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          refclk,
    input  logic          rst,
    input  logic          locked_in,
    output logic          pll_rst,
    output logic          sys_rst,
    output logic          ready,
    output logic          fault,
    output logic [RW-1:0] retry_count
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    ,
    output logic [7:0]    lock_loss_cnt
`endif
);

    localparam logic [2:0] RESET_PLL = 3'd0;
    localparam logic [2:0] WAIT_LOCK = 3'd1;
    localparam logic [2:0] STABLE    = 3'd2;
    localparam logic [2:0] RUN       = 3'd3;
    localparam logic [2:0] FAULT     = 3'd4;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    logic [2:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [RW-1:0] retry, retry_d;
    logic          attempt_fail;
    logic          locked_meta, locked_s;

    // locked_in is asynchronous; only this two-flop chain ever samples it.
    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked_in;
            locked_s    <= locked_meta;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        retry_d      = retry;
        attempt_fail = 1'b0;
        case (state)
            RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same edge.
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    attempt_fail = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    attempt_fail = 1'b1;
                end else if (cnt == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        if (attempt_fail) begin
            cnt_d = '0;
            if (retry == RETRY_MAX) begin
                state_d = FAULT;
            end else begin
                state_d = RESET_PLL;
                retry_d = retry + RW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= RESET_PLL;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            retry <= retry_d;
        end
    end

    assign pll_rst     = (state == RESET_PLL) || (state == FAULT);
    assign sys_rst     = (state != RUN);
    assign ready       = (state == RUN);
    assign fault       = (state == FAULT);
    assign retry_count = retry;

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic loss_event;
    assign loss_event = (state == RUN) && !locked_s;

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_loss_cnt <= 8'h00;
        end else if (loss_event && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Expected values are queued before each stimulus step and popped when the DUT response is measured.
module tb_pll_reset_sequencer;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 2;
    // Edges from locked_in rising in WAIT_LOCK to ready: 2 sync + 1 to STABLE + (SC-1) count + 1 to RUN.
    localparam int LOCK_TO_READY = 2 + 1 + (SC - 1) + 1;

    logic       refclk;
    logic       rst;
    logic       locked_in;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    pll_reset_sequencer #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYCLES(SC),
        .MAX_RETRIES  (MR)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked_in  (locked_in),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_count(retry_count)
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        string tag;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    function automatic void expect_val(input string tag, input int exp);
        sb.push_back('{tag, exp});
    endfunction

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === 32'(e.exp))
            else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return ready;
            default: return 1'b0;
        endcase
    endfunction

    // Counts edges until the selected output reaches val; -1 if the budget expires.
    task automatic edges_until(input int sel, input logic val, input int limit, output int n);
        for (n = 1; n <= limit; n++) begin
            @(negedge refclk);
            if (sel_sig(sel) === val) return;
        end
        n = -1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int bad;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        locked_in = 1'b0;
        repeat (3) @(negedge refclk);

        // Reset state
        expect_val("reset_pll_rst", 1); check(32'(pll_rst));
        expect_val("reset_sys_rst", 1); check(32'(sys_rst));
        expect_val("reset_ready", 0);   check(32'(ready));
        expect_val("reset_fault", 0);   check(32'(fault));
        expect_val("reset_retry", 0);   check(32'(retry_count));

        // Normal lock
        expect_val("normal_pll_rst_high", RC);
        rst = 1'b0;
        edges_until(0, 1'b0, 50, n); check(32'(n));
        repeat (4) @(negedge refclk);
        expect_val("normal_ready_edges", LOCK_TO_READY);
        locked_in = 1'b1;
        edges_until(1, 1'b1, 50, n); check(32'(n));
        expect_val("normal_sys_rst", 0); check(32'(sys_rst));
        expect_val("normal_retry", 0);   check(32'(retry_count));

        // Loss in RUN
        expect_val("loss_ready_edges", 3);
        locked_in = 1'b0;
        edges_until(1, 1'b0, 10, n); check(32'(n));
        expect_val("loss_sys_rst", 1); check(32'(sys_rst));
        expect_val("loss_pll_rst", 1); check(32'(pll_rst));
        expect_val("loss_retry", 0);   check(32'(retry_count));
        expect_val("loss_pll_rst_high", RC);
        edges_until(0, 1'b0, 20, n); check(32'(n));
        repeat (2) @(negedge refclk);
        expect_val("loss_relock_ready_edges", LOCK_TO_READY);
        locked_in = 1'b1;
        edges_until(1, 1'b1, 50, n); check(32'(n));
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        expect_val("loss_cnt_1", 1); check(32'(lock_loss_cnt));
`endif

        // Glitch in STABLE: drop locked_in for 3 cycles once STABLE cnt reaches 4
        expect_val("glitch_prep_ready_edges", 3);
        locked_in = 1'b0;
        edges_until(1, 1'b0, 10, n); check(32'(n));
        expect_val("glitch_prep_pll_rst_high", RC);
        edges_until(0, 1'b0, 20, n); check(32'(n));
        repeat (2) @(negedge refclk);
        locked_in = 1'b1;
        repeat (7) @(negedge refclk);
        locked_in = 1'b0;
        repeat (3) @(negedge refclk);
        locked_in = 1'b1;
        expect_val("glitch_retry", 1);   check(32'(retry_count));
        expect_val("glitch_pll_rst", 1); check(32'(pll_rst));
        expect_val("glitch_ready", 0);   check(32'(ready));
        expect_val("glitch_pll_rst_high", RC);
        edges_until(0, 1'b0, 20, n); check(32'(n));
        // locked_s is already high on WAIT_LOCK entry: 1 edge to STABLE, SC-1 to count, 1 to RUN
        expect_val("glitch_ready_edges", 1 + (SC - 1) + 1);
        edges_until(1, 1'b1, 50, n); check(32'(n));
        expect_val("glitch_retry_in_run", 1); check(32'(retry_count));
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        expect_val("loss_cnt_2", 2); check(32'(lock_loss_cnt));
`endif

        // Never locks: MR+1 attempts, then FAULT
        expect_val("never_ready_edges", 3);
        locked_in = 1'b0;
        edges_until(1, 1'b0, 10, n); check(32'(n));
        expect_val("never_fresh_retry", 0); check(32'(retry_count));
        for (int a = 0; a <= MR; a++) begin
            expect_val($sformatf("never_pulse%0d_high", a), RC);
            edges_until(0, 1'b0, 20, n); check(32'(n));
            expect_val($sformatf("never_pulse%0d_low", a), LT);
            edges_until(0, 1'b1, 40, n); check(32'(n));
            expect_val($sformatf("never_retry%0d", a), (a < MR) ? a + 1 : MR);
            check(32'(retry_count));
        end
        expect_val("never_fault", 1);   check(32'(fault));
        expect_val("never_sys_rst", 1); check(32'(sys_rst));
        repeat (30) @(negedge refclk);
        expect_val("fault_hold_fault", 1);   check(32'(fault));
        expect_val("fault_hold_pll_rst", 1); check(32'(pll_rst));
        expect_val("fault_hold_retry", MR);  check(32'(retry_count));
        expect_val("fault_hold_ready", 0);   check(32'(ready));
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        expect_val("loss_cnt_3", 3); check(32'(lock_loss_cnt));
`endif

        // rst in FAULT
        rst = 1'b1;
        @(negedge refclk);
        expect_val("rst_fault_pll_rst", 1); check(32'(pll_rst));
        expect_val("rst_fault_fault", 0);   check(32'(fault));
        expect_val("rst_fault_retry", 0);   check(32'(retry_count));
        rst = 1'b0;

        // rst mid-WAIT_LOCK with a nonzero retry count
        expect_val("mid_pll_rst_high", RC);
        edges_until(0, 1'b0, 20, n); check(32'(n));
        expect_val("mid_first_low", LT);
        edges_until(0, 1'b1, 40, n); check(32'(n));
        expect_val("mid_retry_before", 1); check(32'(retry_count));
        expect_val("mid_second_high", RC);
        edges_until(0, 1'b0, 20, n); check(32'(n));
        repeat (10) @(negedge refclk);
        expect_val("mid_still_waiting", 0); check(32'(pll_rst));
        rst = 1'b1;
        @(negedge refclk);
        expect_val("mid_rst_pll_rst", 1); check(32'(pll_rst));
        expect_val("mid_rst_retry", 0);   check(32'(retry_count));
        expect_val("mid_rst_fault", 0);   check(32'(fault));
`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        expect_val("loss_cnt_rst", 0); check(32'(lock_loss_cnt));
`endif
        expect_val("mid_after_rst_high", RC);
        rst = 1'b0;
        edges_until(0, 1'b0, 20, n); check(32'(n));

`ifdef PLL_RESET_SEQUENCER_LOSS_CNT_EN
        // Saturation after 300 RUN losses
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            locked_in = 1'b1;
            edges_until(1, 1'b1, 60, n);
            if (n < 0) bad++;
            locked_in = 1'b0;
            edges_until(1, 1'b0, 10, n);
            if (n < 0) bad++;
        end
        expect_val("sat_timeouts", 0);    check(32'(bad));
        expect_val("sat_cnt", 8'hFF);     check(32'(lock_loss_cnt));
        rst = 1'b1;
        @(negedge refclk);
        expect_val("sat_rst_cnt", 0);     check(32'(lock_loss_cnt));
        rst = 1'b0;
`else
        bad = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
